// File: rtl/gemm_job_scheduler.sv
// gemm_job_scheduler: round-robin front-end that lets NumReq requesters share
// one GeMM engine. Each grant accepts one (M, K, N) job descriptor and checks
// it against the engine tile sizes. A legal job gets a one-cycle start pulse
// and the scheduler waits for the engine's done. An illegal job is rejected
// without starting the engine. Either way, a completion record (id, err) is
// returned over a valid/ready handshake.
// Optional build macro: GEMM_SCHED_PERF_EN adds cmp_cycles_o, the number of
// Run cycles the job took, saturating at 32 bits.

module gemm_job_scheduler #(
   parameter int unsigned NumReq    = 2,
   parameter int unsigned AddrWidth = 16,
   parameter int unsigned TileM     = 4,
   parameter int unsigned TileK     = 4,
   parameter int unsigned TileN     = 4,
   parameter int unsigned IdWidth   = $clog2(NumReq)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumReq-1:0]             req_valid_i,
   output logic [NumReq-1:0]             req_ready_o,
   input  logic [NumReq*AddrWidth-1:0]   req_m_size_i,
   input  logic [NumReq*AddrWidth-1:0]   req_k_size_i,
   input  logic [NumReq*AddrWidth-1:0]   req_n_size_i,
   output logic                          eng_start_o,
   output logic [AddrWidth-1:0]          eng_m_size_o,
   output logic [AddrWidth-1:0]          eng_k_size_o,
   output logic [AddrWidth-1:0]          eng_n_size_o,
   input  logic                          eng_done_i,
   output logic                          cmp_valid_o,
   input  logic                          cmp_ready_i,
   output logic [IdWidth-1:0]            cmp_id_o,
   output logic                          cmp_err_o,
`ifdef GEMM_SCHED_PERF_EN
   output logic [31:0]                   cmp_cycles_o,
`endif
   output logic                          busy_o
);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StRun,
      StReport
   } state_e;

   // Tiles are powers of two, so a size is a tile multiple when its low bits are zero.
   localparam logic [AddrWidth-1:0] MaskM = AddrWidth'(TileM - 1);
   localparam logic [AddrWidth-1:0] MaskK = AddrWidth'(TileK - 1);
   localparam logic [AddrWidth-1:0] MaskN = AddrWidth'(TileN - 1);
   localparam logic [IdWidth:0]     NumReqW = (IdWidth + 1)'(NumReq);
   localparam logic [IdWidth-1:0]   LastId  = IdWidth'(NumReq - 1);

   state_e               state_q;
   logic [IdWidth-1:0]   rr_ptr_q;
   logic [IdWidth-1:0]   rr_ptr_d;
   logic [IdWidth-1:0]   id_q;
   logic                 err_q;
   logic                 eng_start_q;
   logic                 cmp_valid_q;
   logic                 busy_q;
   logic [AddrWidth-1:0] m_size_q;
   logic [AddrWidth-1:0] k_size_q;
   logic [AddrWidth-1:0] n_size_q;
`ifdef GEMM_SCHED_PERF_EN
   logic [31:0]          cycles_q;
`endif

   logic                 grant_vld;
   logic [IdWidth-1:0]   grant_idx;
   logic [IdWidth:0]     cand;
   logic [AddrWidth-1:0] sel_m;
   logic [AddrWidth-1:0] sel_k;
   logic [AddrWidth-1:0] sel_n;
   logic                 sel_err;

   // Round-robin search from rr_ptr_q upwards (mod NumReq); the first valid requester wins.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch can be inferred.
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         cand = {1'b0, rr_ptr_q} + (IdWidth + 1)'(i);
         if (cand >= NumReqW) begin
            cand = cand - NumReqW;
         end
         if (!grant_vld && req_valid_i[cand[IdWidth-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[IdWidth-1:0];
         end
      end
   end

   // Descriptor of the granted requester and its legality against the tile sizes.
   always_comb begin
      sel_m   = req_m_size_i[grant_idx*AddrWidth +: AddrWidth];
      sel_k   = req_k_size_i[grant_idx*AddrWidth +: AddrWidth];
      sel_n   = req_n_size_i[grant_idx*AddrWidth +: AddrWidth];
      sel_err = (sel_m == '0) || ((sel_m & MaskM) != '0) ||
                (sel_k == '0) || ((sel_k & MaskK) != '0) ||
                (sel_n == '0) || ((sel_n & MaskN) != '0);
   end

   // The grant is offered only from Idle, and it is held off while reset is asserted.
   always_comb begin
      req_ready_o = '0;
      if (rst_ni && (state_q == StIdle) && grant_vld) begin
         req_ready_o[grant_idx] = 1'b1;
      end
   end

   assign rr_ptr_d = (grant_idx == LastId) ? '0 : grant_idx + 1'b1;

   // Job sequencing FSM: Idle -> (Start -> Run ->) Report -> Idle, with registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         err_q       <= 1'b0;
         eng_start_q <= 1'b0;
         cmp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         m_size_q    <= '0;
         k_size_q    <= '0;
         n_size_q    <= '0;
`ifdef GEMM_SCHED_PERF_EN
         cycles_q    <= '0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
         eng_start_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (grant_vld) begin
                  m_size_q <= sel_m;
                  k_size_q <= sel_k;
                  n_size_q <= sel_n;
                  id_q     <= grant_idx;
                  err_q    <= sel_err;
                  rr_ptr_q <= rr_ptr_d;
                  busy_q   <= 1'b1;
`ifdef GEMM_SCHED_PERF_EN
                  cycles_q <= '0;
`endif
                  if (sel_err) begin
                     state_q     <= StReport;
                     cmp_valid_q <= 1'b1;
                  end else begin
                     state_q     <= StStart;
                     eng_start_q <= 1'b1;
                  end
               end
            end
            StStart: begin
               state_q <= StRun;
            end
            StRun: begin
`ifdef GEMM_SCHED_PERF_EN
               if (cycles_q != 32'hFFFF_FFFF) begin
                  cycles_q <= cycles_q + 32'd1;
               end
`endif
               if (eng_done_i) begin
                  state_q     <= StReport;
                  cmp_valid_q <= 1'b1;
               end
            end
            StReport: begin
               if (cmp_ready_i) begin
                  state_q     <= StIdle;
                  cmp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign eng_start_o  = eng_start_q;
   assign eng_m_size_o = m_size_q;
   assign eng_k_size_o = k_size_q;
   assign eng_n_size_o = n_size_q;
   assign cmp_valid_o  = cmp_valid_q;
   assign cmp_id_o     = id_q;
   assign cmp_err_o    = err_q;
   assign busy_o       = busy_q;
`ifdef GEMM_SCHED_PERF_EN
   assign cmp_cycles_o = cycles_q;
`endif

endmodule

// File: tb/tb_gemm_job_scheduler.sv
// tb_gemm_job_scheduler: randomized bench for gemm_job_scheduler. A timeline
// model predicts the arbitration winner, the start-pulse cycle, the
// completion cycle and record, and the latched sizes from the scheduling
// rules. A small engine model answers each start after a chosen latency, and
// it injects done pulses only where they must be ignored.

module tb_gemm_job_scheduler;
   localparam int NR   = 2;
   localparam int AW   = 16;
   localparam int TILE = 4;
   localparam int BIG  = 32'h7fff_ffff;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [NR-1:0]     req_valid_i;
   logic [NR-1:0]     req_ready_o;
   logic [NR*AW-1:0]  req_m_size_i;
   logic [NR*AW-1:0]  req_k_size_i;
   logic [NR*AW-1:0]  req_n_size_i;
   logic              eng_start_o;
   logic [AW-1:0]     eng_m_size_o;
   logic [AW-1:0]     eng_k_size_o;
   logic [AW-1:0]     eng_n_size_o;
   logic              eng_done_i;
   logic              cmp_valid_o;
   logic              cmp_ready_i;
   logic [0:0]        cmp_id_o;
   logic              cmp_err_o;
   logic              busy_o;
`ifdef GEMM_SCHED_PERF_EN
   logic [31:0]       cmp_cycles_o;
`endif

   gemm_job_scheduler #(
      .NumReq   (NR),
      .AddrWidth(AW),
      .TileM    (TILE),
      .TileK    (TILE),
      .TileN    (TILE)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_m_size_i(req_m_size_i),
      .req_k_size_i(req_k_size_i),
      .req_n_size_i(req_n_size_i),
      .eng_start_o (eng_start_o),
      .eng_m_size_o(eng_m_size_o),
      .eng_k_size_o(eng_k_size_o),
      .eng_n_size_o(eng_n_size_o),
      .eng_done_i  (eng_done_i),
      .cmp_valid_o (cmp_valid_o),
      .cmp_ready_i (cmp_ready_i),
      .cmp_id_o    (cmp_id_o),
      .cmp_err_o   (cmp_err_o),
`ifdef GEMM_SCHED_PERF_EN
      .cmp_cycles_o(cmp_cycles_o),
`endif
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   // Stimulus configuration for the current phase.
   logic [NR-1:0] cfg_vmask;
   int            cfg_vpct;
   bit            cfg_fixed;
   logic [AW-1:0] cfg_m, cfg_k, cfg_n;
   int            cfg_lat_min, cfg_lat_max;
   int            cfg_rdy_pct;
   int            cfg_spur_pct;

   // Timeline model of the single job in flight.
   int            exp_rr;
   bit            job_active;
   int            job_id;
   bit            job_err;
   int            grant_cyc, start_cyc, done_cyc, cmp_from;
   int            exp_cycles;
   logic [AW-1:0] last_m, last_k, last_n;
   int            jobs_done, model_starts, dut_cmps, dut_starts;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] rand_size();
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) return '0;
      if (sel == 1) return AW'(TILE * $urandom_range(0, 8) + $urandom_range(1, TILE - 1));
      return AW'(TILE * $urandom_range(1, 8));
   endfunction

   function automatic bit illegal(input logic [AW-1:0] s);
      return (s == 0) || ((s % TILE) != 0);
   endfunction

   task automatic model_reset();
      exp_rr     = 0;
      job_active = 1'b0;
      job_id     = 0;
      job_err    = 1'b0;
      grant_cyc  = -BIG;
      start_cyc  = -1;
      done_cyc   = -1;
      cmp_from   = BIG;
      exp_cycles = 0;
      last_m     = '0;
      last_k     = '0;
      last_n     = '0;
   endtask

   task automatic check_all_zero(input string ph);
      check({ph, "_ready"}, req_ready_o, 0);
      check({ph, "_start"}, eng_start_o, 0);
      check({ph, "_sizes"}, {eng_m_size_o, eng_k_size_o, eng_n_size_o}, 0);
      check({ph, "_cmp_valid"}, cmp_valid_o, 0);
      check({ph, "_cmp_id"}, cmp_id_o, 0);
      check({ph, "_cmp_err"}, cmp_err_o, 0);
      check({ph, "_busy"}, busy_o, 0);
`ifdef GEMM_SCHED_PERF_EN
      check({ph, "_cycles"}, cmp_cycles_o, 0);
`endif
   endtask

   // One clock cycle: drive at the falling edge, compare, then advance the model.
   task automatic tick();
      bit            allow_spur, start_now, exp_cv;
      int            exp_g, r;
      logic [NR-1:0] exp_ready;
      @(negedge clk_i);
      cyc++;
      for (int q = 0; q < NR; q++) begin
         req_valid_i[q] = cfg_vmask[q] && ($urandom_range(0, 99) < cfg_vpct);
         req_m_size_i[q*AW +: AW] = cfg_fixed ? cfg_m : rand_size();
         req_k_size_i[q*AW +: AW] = cfg_fixed ? cfg_k : rand_size();
         req_n_size_i[q*AW +: AW] = cfg_fixed ? cfg_n : rand_size();
      end
      cmp_ready_i = ($urandom_range(0, 99) < cfg_rdy_pct);
      allow_spur  = !job_active || (!job_err && cyc == grant_cyc + 1) || (cyc >= cmp_from);
      eng_done_i  = (cyc == done_cyc) || (allow_spur && ($urandom_range(0, 99) < cfg_spur_pct));
      #1;
      exp_g = -1;
      if (!job_active) begin
         for (int k = 0; k < NR; k++) begin
            r = (exp_rr + k) % NR;
            if (exp_g < 0 && req_valid_i[r]) exp_g = r;
         end
      end
      exp_ready = '0;
      if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
      start_now = job_active && !job_err && (cyc == grant_cyc + 1);
      exp_cv    = job_active && (cyc >= cmp_from);

      check("req_ready", req_ready_o, exp_ready);
      check("ready_onehot0", $onehot0(req_ready_o), 1);
      check("eng_start", eng_start_o, start_now);
      check("busy", busy_o, job_active);
      check("eng_sizes", {eng_m_size_o, eng_k_size_o, eng_n_size_o}, {last_m, last_k, last_n});
      check("cmp_valid", cmp_valid_o, exp_cv);
      if (exp_cv) begin
         check("cmp_id", cmp_id_o, job_id);
         check("cmp_err", cmp_err_o, job_err);
`ifdef GEMM_SCHED_PERF_EN
         check("cmp_cycles", cmp_cycles_o, exp_cycles);
`endif
      end
      if (eng_start_o) dut_starts++;
      if (cmp_valid_o && cmp_ready_i) dut_cmps++;

      if (start_now) begin
         model_starts++;
         start_cyc = cyc;
         done_cyc  = cyc + 1 + int'($urandom_range(cfg_lat_min, cfg_lat_max));
      end
      if (job_active && cyc == done_cyc) begin
         cmp_from   = cyc + 1;
         exp_cycles = done_cyc - start_cyc;
      end
      if (exp_cv && cmp_ready_i) begin
         job_active = 1'b0;
         jobs_done++;
         done_cyc = -1;
         cmp_from = BIG;
      end else if (exp_g >= 0) begin
         job_active = 1'b1;
         job_id     = exp_g;
         grant_cyc  = cyc;
         start_cyc  = -1;
         last_m     = req_m_size_i[exp_g*AW +: AW];
         last_k     = req_k_size_i[exp_g*AW +: AW];
         last_n     = req_n_size_i[exp_g*AW +: AW];
         job_err    = illegal(last_m) || illegal(last_k) || illegal(last_n);
         cmp_from   = job_err ? cyc + 1 : BIG;
         exp_cycles = 0;
         exp_rr     = (exp_g + 1) % NR;
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_jobs(input int n);
      int target, budget;
      target = jobs_done + n;
      budget = n * 200;
      while (jobs_done < target && budget > 0) begin
         tick();
         budget--;
      end
   endtask

   task automatic set_cfg(input logic [NR-1:0] vmask, input int vpct, input bit fixed,
                          input int m, input int k, input int n, input int lmin,
                          input int lmax, input int rdy, input int spur);
      cfg_vmask = vmask;  cfg_vpct = vpct;  cfg_fixed = fixed;
      cfg_m = AW'(m);     cfg_k = AW'(k);   cfg_n = AW'(n);
      cfg_lat_min = lmin; cfg_lat_max = lmax;
      cfg_rdy_pct = rdy;  cfg_spur_pct = spur;
   endtask

   // Reset in the middle of a Run phase, then release and restart the model.
   task automatic reset_mid_run();
      int budget;
      set_cfg(2'b01, 100, 1'b1, 8, 8, 8, 20, 20, 100, 0);
      budget = 50;
      while (!(job_active && start_cyc >= 0) && budget > 0) begin
         tick();
         budget--;
      end
      @(posedge clk_i);
      #2;
      rst_ni      = 1'b0;
      req_valid_i = '1;
      #1;
      check_all_zero("mid_run_reset");
      req_valid_i = '0;
      eng_done_i  = 1'b0;
      cmp_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      model_reset();
   endtask

   initial begin
      rst_ni       = 1'b0;
      req_valid_i  = '1;
      req_m_size_i = '0;
      req_k_size_i = '0;
      req_n_size_i = '0;
      eng_done_i   = 1'b0;
      cmp_ready_i  = 1'b0;
      jobs_done = 0; model_starts = 0; dut_cmps = 0; dut_starts = 0;
      model_reset();
      #3;
      check_all_zero("por");
      req_valid_i = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Single legal 8x8x8 job from requester 0, engine done 10 cycles after start.
      set_cfg(2'b01, 100, 1'b1, 8, 8, 8, 9, 9, 100, 0);
      run_jobs(1);
      // Both requesters busy with 4x4x4 jobs and an instant engine: grants alternate.
      set_cfg(2'b11, 100, 1'b1, 4, 4, 4, 0, 0, 100, 0);
      run_jobs(8);
      // Rejected descriptors: K not a tile multiple, then N of zero.
      set_cfg(2'b10, 100, 1'b1, 8, 6, 8, 0, 0, 100, 0);
      run_jobs(1);
      set_cfg(2'b10, 100, 1'b1, 8, 8, 0, 0, 0, 100, 0);
      run_jobs(1);
      // Consumer stalls the completion while done pulses arrive outside Run.
      set_cfg(2'b11, 100, 1'b1, 4, 8, 4, 2, 2, 0, 100);
      run_cycles(12);
      set_cfg(2'b11, 100, 1'b1, 4, 8, 4, 2, 2, 100, 100);
      run_jobs(1);
      // Reset during Run, then a fresh job from requester 1 alone.
      reset_mid_run();
      set_cfg(2'b10, 100, 1'b1, 16, 4, 8, 3, 3, 100, 0);
      run_jobs(1);
      // Done on the 12th Run cycle.
      set_cfg(2'b01, 100, 1'b1, 4, 4, 4, 11, 11, 100, 0);
      run_jobs(1);
      // Random mix of valids, sizes, latencies, back-pressure and stray done pulses.
      set_cfg(2'b11, 40, 1'b0, 0, 0, 0, 0, 5, 50, 30);
      run_cycles(2000);

      check("dut_cmp_count", dut_cmps, jobs_done);
      check("dut_start_count", dut_starts, model_starts);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
